amo_unit: RTL and testbench

Atomic-memory sequencer for the RV32A path of the core. It accepts one decoded atomic instruction (LR.W, SC.W, or AMO*.W) from the memory stage, issues the read and/or write transactions to the data-memory port, and returns the rd writeback value. It consumes the combinational `reserved` flag from the LR/SC reservation set in the start cycle. It is the initiator side of the LR/SC protocol, where the reservation set is the bookkeeping side.

---
 rtl/amo_unit.sv | 196 +++++++++++++++++++
 tb/tb_amo_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_unit.sv
// RV32A atomic-memory sequencer: runs LR.W / SC.W / AMO*.W as read and/or write
// transfers on the data-memory port and returns the rd writeback value.
module amo_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           instruction,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  reserved,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  misaligned,
  output logic                  illegal
);

  localparam logic [4:0] F5Lr   = 5'b00010;
  localparam logic [4:0] F5Sc   = 5'b00011;
  localparam logic [4:0] F5Swap = 5'b00001;
  localparam logic [4:0] F5Add  = 5'b00000;
  localparam logic [4:0] F5Xor  = 5'b00100;
  localparam logic [4:0] F5And  = 5'b01100;
  localparam logic [4:0] F5Or   = 5'b01000;
  localparam logic [4:0] F5Min  = 5'b10000;
  localparam logic [4:0] F5Max  = 5'b10100;
  localparam logic [4:0] F5Minu = 5'b11000;
  localparam logic [4:0] F5Maxu = 5'b11100;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [4:0]            funct5_q, funct5_d;
  logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0] old_q, old_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic                  mis_q, mis_d;
  logic                  ill_q, ill_d;

  logic [2:0]            funct3;
  logic [4:0]            funct5;
  logic                  legal;
  logic [DATA_WIDTH-1:0] amo_new;
  logic                  unused_instr;

  assign funct3       = instruction[14:12];
  assign funct5       = instruction[31:27];
  assign unused_instr = ^{instruction[26:15], instruction[11:0]};

  always_comb begin
    legal = 1'b0;
    if (funct3 == 3'b010) begin
      case (funct5)
        F5Lr, F5Sc, F5Swap, F5Add, F5Xor, F5And, F5Or,
        F5Min, F5Max, F5Minu, F5Maxu: legal = 1'b1;
        default:                      legal = 1'b0;
      endcase
    end
  end

  // New memory value, computed from the read data in the read-ack cycle.
  always_comb begin
    amo_new = rs2_q;
    case (funct5_q)
      F5Add:  amo_new = mem_rdata + rs2_q;
      F5Xor:  amo_new = mem_rdata ^ rs2_q;
      F5And:  amo_new = mem_rdata & rs2_q;
      F5Or:   amo_new = mem_rdata | rs2_q;
      F5Min:  amo_new = ($signed(mem_rdata) < $signed(rs2_q)) ? mem_rdata : rs2_q;
      F5Max:  amo_new = ($signed(mem_rdata) > $signed(rs2_q)) ? mem_rdata : rs2_q;
      F5Minu: amo_new = (mem_rdata < rs2_q) ? mem_rdata : rs2_q;
      F5Maxu: amo_new = (mem_rdata > rs2_q) ? mem_rdata : rs2_q;
      default: amo_new = rs2_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    funct5_d = funct5_q;
    rs2_d    = rs2_q;
    old_d    = old_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    req_d    = req_q;
    we_d     = we_q;
    mis_d    = mis_q;
    ill_d    = ill_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          funct5_d = funct5;
          rs2_d    = rs2_data;
          addr_d   = {rs1_data[DATA_WIDTH-1:2], 2'b00};
          mis_d    = (rs1_data[1:0] != 2'b00);
          ill_d    = !legal;
          if (!legal || (rs1_data[1:0] != 2'b00)) begin
            rd_d    = '0;
            state_d = StDone;
          end else if (funct5 == F5Sc) begin
            if (reserved) begin
              req_d   = 1'b1;
              we_d    = 1'b1;
              wdata_d = rs2_data;
              state_d = StWrite;
            end else begin
              rd_d    = DATA_WIDTH'(1);
              state_d = StDone;
            end
          end else begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (mem_ack) begin
          if (funct5_q == F5Lr) begin
            rd_d    = mem_rdata;
            req_d   = 1'b0;
            state_d = StDone;
          end else begin
            old_d   = mem_rdata;
            wdata_d = amo_new;
            we_d    = 1'b1;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (mem_ack) begin
          rd_d    = (funct5_q == F5Sc) ? '0 : old_q;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      funct5_q <= '0;
      rs2_q    <= '0;
      old_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct5_q <= funct5_d;
      rs2_q    <= rs2_d;
      old_q    <= old_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      req_q    <= req_d;
      we_q     <= we_d;
      mis_q    <= mis_d;
      ill_q    <= ill_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rd_data    = rd_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign misaligned = mis_q & done;
  assign illegal    = ill_q & done;

endmodule

// File: tb/tb_amo_unit.sv
// Self-checking bench for amo_unit: behavioural memory with configurable ack delay,
// expected writeback results queued at issue time and compared at done.
module tb_amo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        reserved = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy, done, misaligned, illegal;
  logic [31:0] rd_data;

  amo_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .reserved(reserved),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done),
    .rd_data(rd_data), .misaligned(misaligned), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  int ack_delay = 0;
  int wcnt = 0;
  int req_cnt = 0;
  int ack_cnt = 0;
  int stab_err = 0;

  logic [31:0] obs_rd;
  logic        obs_mis, obs_ill;
  int          obs_lat;

  // Memory responder: ack after ack_delay wait cycles.
  always @(negedge clk) begin
    if (mem_req) begin
      req_cnt++;
      if (wcnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      ack_cnt++;
      wcnt = 0;
    end
  end

  // Request fields must hold while a transfer waits for its ack.
  logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  always @(negedge clk) begin
    #2;
    if (p_req && !p_ack && mem_req &&
        (mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wdata)) stab_err++;
    p_req = mem_req; p_ack = mem_ack; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
  end

  function automatic logic [31:0] mk(input logic [4:0] f5, input logic [2:0] f3);
    return {f5, 2'b00, 5'd2, 5'd1, f3, 5'd3, 7'b0101111};
  endfunction

  function automatic logic [31:0] amo_ref(input logic [4:0] f5, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f5)
      5'b00001: return b;
      5'b00000: return a + b;
      5'b00100: return a ^ b;
      5'b01100: return a & b;
      5'b01000: return a | b;
      5'b10000: return ($signed(a) <= $signed(b)) ? a : b;
      5'b10100: return ($signed(a) >= $signed(b)) ? a : b;
      5'b11000: return (a <= b) ? a : b;
      default:  return (a >= b) ? a : b;
    endcase
  endfunction

  // Drive one start and wait (bounded) for done; hold keeps start high and
  // changes the operands mid-flight to show they are ignored.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic res, input bit hold);
    @(negedge clk);
    start = 1'b1; instruction = ins; rs1_data = a; rs2_data = b; reserved = res;
    @(posedge clk);
    obs_lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (hold && n == 2) begin
        instruction = mk(5'b00011, 3'b010); rs1_data = 32'h500; rs2_data = 32'h0;
        reserved = 1'b0;
      end
      if (done) begin
        obs_rd = rd_data; obs_mis = misaligned; obs_ill = illegal; obs_lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    #3;
    checks++;
    if ({mem_req, busy, done, mem_we, misaligned, illegal} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {mem_req, busy, done, mem_we, misaligned, illegal});
    end
    checks++;
    if ({mem_addr, mem_wdata, rd_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h expected zeros", mem_addr, mem_wdata, rd_data);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
    e.rd = 0; // keep e used
  endtask

  task automatic test_amoadd;
    exp_t e;
    int r0;
    mem[32'h100] = 32'hFFFF_FFFE;
    ack_delay = 0; r0 = req_cnt;
    sb.push_back('{rd: 32'hFFFF_FFFE, mis: 1'b0, ill: 1'b0, lat: 3});
    issue(mk(5'b00000, 3'b010), 32'h100, 32'h5, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd) begin errors++; $display("FAIL amoadd_rd: got %h expected %h", obs_rd, e.rd); end
    checks++;
    if (obs_lat != e.lat) begin errors++; $display("FAIL amoadd_lat: got %0d expected %0d", obs_lat, e.lat); end
    checks++;
    if (mem[32'h100] !== 32'h3) begin errors++; $display("FAIL amoadd_mem: got %h expected 00000003", mem[32'h100]); end
    checks++;
    if (req_cnt - r0 != 2) begin errors++; $display("FAIL amoadd_reqs: got %0d expected 2", req_cnt - r0); end
  endtask

  task automatic test_lr_sc;
    exp_t e;
    mem[32'h200] = 32'hDEAD_BEEF;
    sb.push_back('{rd: 32'hDEAD_BEEF, mis: 1'b0, ill: 1'b0, lat: 2});
    issue(mk(5'b00010, 3'b010), 32'h200, 32'h0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_lat != e.lat) begin
      errors++; $display("FAIL lr: got rd=%h lat=%0d expected rd=%h lat=%0d", obs_rd, obs_lat, e.rd, e.lat);
    end
    sb.push_back('{rd: 32'h0, mis: 1'b0, ill: 1'b0, lat: 2});
    issue(mk(5'b00011, 3'b010), 32'h200, 32'h1234, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_lat != e.lat) begin
      errors++; $display("FAIL sc_ok: got rd=%h lat=%0d expected rd=%h lat=%0d", obs_rd, obs_lat, e.rd, e.lat);
    end
    checks++;
    if (mem[32'h200] !== 32'h1234) begin errors++; $display("FAIL sc_ok_mem: got %h expected 00001234", mem[32'h200]); end
  endtask

  task automatic test_sc_fail;
    exp_t e;
    int r0;
    r0 = req_cnt;
    sb.push_back('{rd: 32'h1, mis: 1'b0, ill: 1'b0, lat: 1});
    issue(mk(5'b00011, 3'b010), 32'h200, 32'h9999, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_lat != e.lat) begin
      errors++; $display("FAIL sc_fail: got rd=%h lat=%0d expected rd=%h lat=%0d", obs_rd, obs_lat, e.rd, e.lat);
    end
    checks++;
    if (req_cnt != r0 || mem[32'h200] !== 32'h1234) begin
      errors++; $display("FAIL sc_fail_noreq: got reqs=%0d mem=%h expected 0 00001234", req_cnt - r0, mem[32'h200]);
    end
  endtask

  task automatic test_min_minu;
    exp_t e;
    mem[32'h300] = 32'h8000_0000;
    sb.push_back('{rd: 32'h8000_0000, mis: 1'b0, ill: 1'b0, lat: 3});
    issue(mk(5'b10000, 3'b010), 32'h300, 32'h1, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || mem[32'h300] !== 32'h8000_0000) begin
      errors++; $display("FAIL amomin: got rd=%h mem=%h expected rd=%h mem=80000000", obs_rd, mem[32'h300], e.rd);
    end
    mem[32'h300] = 32'h8000_0000;
    sb.push_back('{rd: 32'h8000_0000, mis: 1'b0, ill: 1'b0, lat: 3});
    issue(mk(5'b11000, 3'b010), 32'h300, 32'h1, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || mem[32'h300] !== 32'h1) begin
      errors++; $display("FAIL amominu: got rd=%h mem=%h expected rd=%h mem=00000001", obs_rd, mem[32'h300], e.rd);
    end
  endtask

  task automatic test_amo_ops;
    exp_t e;
    logic [4:0]  f5s [9] = '{5'b00001, 5'b00000, 5'b00100, 5'b01100, 5'b01000,
                             5'b10000, 5'b10100, 5'b11000, 5'b11100};
    logic [31:0] a, b, adr, want;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 9; i++) begin
        a = $urandom; b = (r == 0) ? $urandom : ~a;
        adr = 32'h600 + 32'(i * 4);
        mem[adr] = a;
        want = amo_ref(f5s[i], a, b);
        sb.push_back('{rd: a, mis: 1'b0, ill: 1'b0, lat: 3});
        issue(mk(f5s[i], 3'b010), adr, b, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs_rd !== e.rd || obs_lat != e.lat || mem[adr] !== want) begin
          errors++;
          $display("FAIL amo_op f5=%b: got rd=%h lat=%0d mem=%h expected rd=%h lat=%0d mem=%h",
                   f5s[i], obs_rd, obs_lat, mem[adr], e.rd, e.lat, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int a0, s0, extra;
    mem[32'h400] = 32'hAAAA_5555;
    ack_delay = 3; a0 = ack_cnt; s0 = stab_err;
    sb.push_back('{rd: 32'hAAAA_5555, mis: 1'b0, ill: 1'b0, lat: 9});
    issue(mk(5'b00001, 3'b010), 32'h400, 32'h1234_5678, 1'b0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_lat != e.lat) begin
      errors++; $display("FAIL swap_wait: got rd=%h lat=%0d expected rd=%h lat=%0d", obs_rd, obs_lat, e.rd, e.lat);
    end
    checks++;
    if (mem[32'h400] !== 32'h1234_5678) begin errors++; $display("FAIL swap_mem: got %h expected 12345678", mem[32'h400]); end
    checks++;
    if (stab_err != s0) begin errors++; $display("FAIL swap_stable: got %0d changes expected 0", stab_err - s0); end
    extra = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (busy || done || mem_req) extra++;
    end
    checks++;
    if (extra != 0 || ack_cnt - a0 != 2) begin
      errors++; $display("FAIL swap_ignored_start: got extra=%0d acks=%0d expected 0 2", extra, ack_cnt - a0);
    end
    ack_delay = 0;
  endtask

  task automatic test_misaligned_illegal;
    exp_t e;
    int r0;
    r0 = req_cnt;
    sb.push_back('{rd: 32'h0, mis: 1'b1, ill: 1'b0, lat: 1});
    issue(mk(5'b00010, 3'b010), 32'h102, 32'h0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_mis !== e.mis || obs_ill !== e.ill || obs_lat != e.lat) begin
      errors++; $display("FAIL misaligned: got rd=%h mis=%b ill=%b lat=%0d expected %h %b %b %0d",
                         obs_rd, obs_mis, obs_ill, obs_lat, e.rd, e.mis, e.ill, e.lat);
    end
    sb.push_back('{rd: 32'h0, mis: 1'b0, ill: 1'b1, lat: 1});
    issue(mk(5'b00110, 3'b010), 32'h100, 32'h0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_mis !== e.mis || obs_ill !== e.ill || obs_lat != e.lat) begin
      errors++; $display("FAIL illegal_f5: got rd=%h mis=%b ill=%b lat=%0d expected %h %b %b %0d",
                         obs_rd, obs_mis, obs_ill, obs_lat, e.rd, e.mis, e.ill, e.lat);
    end
    sb.push_back('{rd: 32'h0, mis: 1'b0, ill: 1'b1, lat: 1});
    issue(mk(5'b00000, 3'b011), 32'h100, 32'h0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs_ill !== e.ill || obs_lat != e.lat) begin
      errors++; $display("FAIL illegal_f3: got ill=%b lat=%0d expected %b %0d", obs_ill, obs_lat, e.ill, e.lat);
    end
    checks++;
    if (req_cnt != r0) begin errors++; $display("FAIL mis_ill_noreq: got %0d reqs expected 0", req_cnt - r0); end
  endtask

  task automatic test_reset_mid;
    int seen, dn;
    ack_delay = 10; seen = 0;
    mem[32'h700] = 32'h5;
    @(negedge clk);
    start = 1'b1; instruction = mk(5'b00001, 3'b010); rs1_data = 32'h700; rs2_data = 32'h77;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (mem_req && mem_we) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL rst_mid_reach_write: got %0d expected 1", seen); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got req=%b busy=%b expected 0 0", mem_req, busy);
    end
    dn = 0;
    for (int n = 0; n < 3; n++) begin @(negedge clk); if (done) dn++; end
    rst = 1'b1; ack_delay = 0;
    for (int n = 0; n < 3; n++) begin @(negedge clk); if (done || busy || mem_req) dn++; end
    checks++;
    if (dn != 0 || rd_data !== 32'h0 || mem[32'h700] !== 32'h5) begin
      errors++; $display("FAIL rst_mid_nodone: got dn=%0d rd=%h mem=%h expected 0 00000000 00000005",
                         dn, rd_data, mem[32'h700]);
    end
  endtask

  initial begin
    test_reset();
    test_amoadd();
    test_lr_sc();
    test_sc_fail();
    test_min_minu();
    test_amo_ops();
    test_back_to_back();
    test_misaligned_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
